cella_bank_ctrl: RTL and testbench

- Command sequencer directly upstream of the CELLA memory bank (4 rows x 8-bit, MAC/CAM dual mode).
- Accepts one command at a time over a valid/ready interface and drives the bank's control pins with correct hold timing and MAC/CAM mode switching: CS, MAC_en, w_en, read_bar, addr, word, query.
- Captures bank read data or CAM match lines and returns one response per read/search.

---
 rtl/cella_bank_ctrl_if.sv | 24 ++
 rtl/cella_bank_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_cella_bank_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cella_bank_ctrl_if.sv
// rtl/cella_bank_ctrl_if.sv - command/response handshake bundle for the CELLA bank sequencer
interface cella_bank_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [3:0] cmd_key;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_hit;
  logic [1:0] rsp_idx;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_key, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_hit, rsp_idx
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_key, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_hit, rsp_idx
  );
endinterface

// File: rtl/cella_bank_ctrl.sv
// rtl/cella_bank_ctrl.sv - one-at-a-time command sequencer driving the CELLA MAC/CAM bank pins
module cella_bank_ctrl #(
  parameter int WR_CYCLES      = 1,
  parameter int RD_CYCLES      = 2,
  parameter int SRCH_CYCLES    = 2,
  parameter int MODE_SW_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  cella_bank_ctrl_if.slave bus,
  output logic             CS,
  output logic             MAC_en,
  output logic             w_en,
  output logic             read_bar,
  output logic [1:0]       addr,
  output logic [7:0]       word,
  output logic [3:0]       query,
  input  logic [7:0]       bank_rdata,
  input  logic [3:0]       bank_match
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_SWITCH, S_WRITE, S_READ, S_SEARCH, S_RESP
  } state_t;

  localparam logic [1:0] OP_WRITE   = 2'd0;
  localparam logic [1:0] OP_READ_QB = 2'd2;
  localparam logic [1:0] OP_SEARCH  = 2'd3;

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] op_q, addr_q;
  logic [7:0] wdata_q;
  logic [3:0] key_q;
  logic       cmd_ready_q, rsp_valid_q, rsp_hit_q;
  logic [7:0] rsp_data_q;
  logic [1:0] rsp_idx_q;

  logic       accept, need_switch, launch;
  logic [1:0] op_n, addr_n, low_idx;
  logic [7:0] wdata_n;
  logic [3:0] key_n;

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_idx   = rsp_idx_q;

  assign accept      = (state == S_IDLE) && bus.cmd_valid && cmd_ready_q;
  // MAC/SRAM ops need MAC_en=1, CAM search needs MAC_en=0
  assign need_switch = (bus.cmd_op != OP_SEARCH) != MAC_en;
  assign launch      = (accept && !need_switch) || (state == S_SWITCH && cnt == 8'd0);

  // Launch straight from IDLE uses the live command; after a switch, the latched copy
  always_comb begin
    op_n    = op_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    key_n   = key_q;
    if (state == S_IDLE) begin
      op_n    = bus.cmd_op;
      addr_n  = bus.cmd_addr;
      wdata_n = bus.cmd_wdata;
      key_n   = bus.cmd_key;
    end
  end

  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bank_match[i]) low_idx = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT;
      cnt         <= 8'd0;
      op_q        <= 2'd0;
      addr_q      <= 2'd0;
      wdata_q     <= 8'd0;
      key_q       <= 4'd0;
      CS          <= 1'b0;
      MAC_en      <= 1'b1;
      w_en        <= 1'b0;
      read_bar    <= 1'b1;
      addr        <= 2'd0;
      word        <= 8'd0;
      query       <= 4'd0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= 2'd0;
    end else begin
      case (state)
        S_INIT: begin
          CS          <= 1'b1;
          cmd_ready_q <= 1'b1;
          state       <= S_IDLE;
        end
        S_IDLE: begin
          if (accept) begin
            op_q        <= bus.cmd_op;
            addr_q      <= bus.cmd_addr;
            wdata_q     <= bus.cmd_wdata;
            key_q       <= bus.cmd_key;
            cmd_ready_q <= 1'b0;
            if (need_switch) begin
              MAC_en <= ~MAC_en;
              cnt    <= 8'(MODE_SW_CYCLES - 1);
              state  <= S_SWITCH;
            end
          end
        end
        S_SWITCH: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
        end
        S_WRITE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            w_en        <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_READ: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            rsp_data_q  <= bank_rdata;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= 2'd0;
            read_bar    <= 1'b1;
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end
        end
        S_SEARCH: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            rsp_data_q  <= {4'b0000, bank_match};
            rsp_hit_q   <= |bank_match;
            rsp_idx_q   <= low_idx;
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase

      // Drive the bank pins for the op; overrides the IDLE/SWITCH next-state above
      if (launch) begin
        case (op_n)
          OP_WRITE: begin
            addr  <= addr_n;
            word  <= wdata_n;
            w_en  <= 1'b1;
            cnt   <= 8'(WR_CYCLES - 1);
            state <= S_WRITE;
          end
          OP_SEARCH: begin
            query <= key_n;
            cnt   <= 8'(SRCH_CYCLES - 1);
            state <= S_SEARCH;
          end
          default: begin
            addr     <= addr_n;
            read_bar <= (op_n == OP_READ_QB);
            cnt      <= 8'(RD_CYCLES - 1);
            state    <= S_READ;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cella_bank_ctrl.sv
// tb/tb_cella_bank_ctrl.sv - directed bench with a cycle-timeline model of cella_bank_ctrl
module tb_cella_bank_ctrl;
  localparam int WR  = 1;
  localparam int RD  = 2;
  localparam int SR  = 2;
  localparam int MSW = 1;

  localparam logic [1:0] OP_WR  = 2'd0;
  localparam logic [1:0] OP_RQ  = 2'd1;
  localparam logic [1:0] OP_RQB = 2'd2;
  localparam logic [1:0] OP_SR  = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       CS, MAC_en, w_en, read_bar;
  logic [1:0] addr;
  logic [7:0] word;
  logic [3:0] query;
  logic [7:0] bank_rdata;
  logic [3:0] bank_match;

  cella_bank_ctrl_if bus ();

  cella_bank_ctrl #(
    .WR_CYCLES(WR), .RD_CYCLES(RD), .SRCH_CYCLES(SR), .MODE_SW_CYCLES(MSW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .CS(CS), .MAC_en(MAC_en), .w_en(w_en), .read_bar(read_bar),
    .addr(addr), .word(word), .query(query),
    .bank_rdata(bank_rdata), .bank_match(bank_match)
  );

  always #5 clk = ~clk;

  // Bank model: SRAM rows written in MAC mode, QB port returns the complement
  logic [7:0] bmem [4];
  always @(posedge clk) if (CS && MAC_en && w_en) bmem[addr] <= word;
  assign bank_rdata = read_bar ? ~bmem[addr] : bmem[addr];

  logic [7:0] exp_mem [4];
  logic       exp_ready, exp_rv, exp_hit, exp_cs, exp_mac, exp_wen, exp_rbar;
  logic [7:0] exp_rdata, exp_word;
  logic [1:0] exp_idx, exp_addr;
  logic [3:0] exp_query;
  logic       chk_en = 1'b0;
  int         passed = 0;
  int         total  = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic [30:0] act, req;
      act = {bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_hit, bus.rsp_idx,
             CS, MAC_en, w_en, read_bar, addr, word, query};
      req = {exp_ready, exp_rv, exp_rdata, exp_hit, exp_idx,
             exp_cs, exp_mac, exp_wen, exp_rbar, exp_addr, exp_word, exp_query};
      total++;
      if (act === req) passed++;
      else $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, req);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  task automatic set_exp_reset();
    exp_ready = 0; exp_rv = 0; exp_rdata = 0; exp_hit = 0; exp_idx = 0;
    exp_cs = 0; exp_mac = 1; exp_wen = 0; exp_rbar = 1;
    exp_addr = 0; exp_word = 0; exp_query = 0;
  endtask

  // Presents one command in the current idle cycle and walks its timeline to the next idle cycle
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] a, input logic [7:0] wd,
                         input logic [3:0] key, input logic [3:0] m, input int bp);
    logic new_mode;
    int   sw, hold, rs, done_k;
    new_mode = (op != OP_SR);
    sw       = (new_mode != exp_mac) ? MSW : 0;
    hold     = (op == OP_WR) ? WR : (op == OP_SR) ? SR : RD;
    rs       = sw + hold + 1;
    done_k   = (op == OP_WR) ? rs : rs + bp + 1;
    bank_match    = m;
    bus.cmd_valid = 1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_wdata = wd; bus.cmd_key = key;
    bus.rsp_ready = (bp == 0);
    @(posedge clk); #1;
    bus.cmd_valid = 0; bus.cmd_op = ~op; bus.cmd_addr = ~a; bus.cmd_wdata = ~wd; bus.cmd_key = ~key;
    exp_ready = 0;
    exp_mac   = new_mode;
    for (int k = 1; k <= done_k; k++) begin
      if (k == sw + 1) begin
        if (op == OP_SR) exp_query = key;
        else exp_addr = a;
        if (op == OP_WR) begin
          exp_word = wd;
          exp_mem[a] = wd;
        end
      end
      exp_wen  = (op == OP_WR) && k > sw && k <= sw + hold;
      exp_rbar = !((op == OP_RQ) && k > sw && k <= sw + hold);
      if (op != OP_WR && k == rs) begin
        exp_rv    = 1;
        exp_rdata = (op == OP_SR) ? {4'b0, m} : (op == OP_RQ) ? exp_mem[a] : ~exp_mem[a];
        exp_hit   = (op == OP_SR) && (m != 4'd0);
        exp_idx   = (op != OP_SR) ? 2'd0 : m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : m[3] ? 2'd3 : 2'd0;
      end
      // Under backpressure, offer a stray command that must be ignored
      if (op != OP_WR && bp > 0 && k >= rs && k < rs + bp) begin
        bus.cmd_valid = 1; bus.cmd_op = OP_WR; bus.cmd_addr = 2'd1; bus.cmd_wdata = 8'hEE;
      end
      if (op != OP_WR && k == rs + bp) begin
        bus.cmd_valid = 0;
        bus.rsp_ready = 1;
      end
      if (k == done_k) begin
        exp_ready = 1;
        exp_rv    = 0;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      bmem[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0; bus.cmd_key = 0;
    bus.rsp_ready = 1; bank_match = 0;
    set_exp_reset();
    rst = 1; chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    exp_cs = 1; exp_ready = 1;
    @(posedge clk); #1;

    run_cmd(OP_WR, 2'd0, 8'hAA, 4'h0, 4'b0000, 0);
    run_cmd(OP_WR, 2'd1, 8'h55, 4'h0, 4'b0000, 0);
    run_cmd(OP_RQ, 2'd0, 8'h00, 4'h0, 4'b0000, 0);
    chk("readq_data", bus.rsp_data, 8'hAA);
    chk("readq_model", exp_rdata, 8'hAA);
    chk("readq_hit", {7'b0, bus.rsp_hit}, 8'h00);
    run_cmd(OP_RQB, 2'd0, 8'h00, 4'h0, 4'b0000, 0);
    chk("readqb_data", bus.rsp_data, 8'h55);
    chk("readqb_model", exp_rdata, 8'h55);
    run_cmd(OP_SR, 2'd0, 8'h00, 4'hA, 4'b0101, 0);
    chk("search_data", bus.rsp_data, 8'h05);
    chk("search_hit", {7'b0, bus.rsp_hit}, 8'h01);
    chk("search_idx", {6'b0, bus.rsp_idx}, 8'h00);
    chk("search_mode", {7'b0, MAC_en}, 8'h00);
    run_cmd(OP_SR, 2'd0, 8'h00, 4'hF, 4'b0000, 0);
    chk("miss_hit", {7'b0, bus.rsp_hit}, 8'h00);
    chk("miss_query", {4'b0, query}, 8'h0F);
    run_cmd(OP_SR, 2'd0, 8'h00, 4'h3, 4'b1100, 0);
    chk("search2_idx", {6'b0, bus.rsp_idx}, 8'h02);
    chk("search2_model_idx", {6'b0, exp_idx}, 8'h02);
    run_cmd(OP_WR, 2'd2, 8'h33, 4'h0, 4'b0000, 0);
    chk("write_switch_mode", {7'b0, MAC_en}, 8'h01);
    run_cmd(OP_RQ, 2'd2, 8'h00, 4'h0, 4'b0000, 5);
    chk("bp_read_data", bus.rsp_data, 8'h33);
    chk("bp_no_stray_write", bmem[1], 8'h55);
    run_cmd(OP_RQB, 2'd1, 8'h00, 4'h0, 4'b0000, 0);
    chk("readqb_row1", bus.rsp_data, 8'hAA);
    run_cmd(OP_WR, 2'd3, 8'hC3, 4'h0, 4'b0000, 0);

    // READ aborted by reset during its first hold cycle
    bus.cmd_valid = 1; bus.cmd_op = OP_RQ; bus.cmd_addr = 2'd3;
    @(posedge clk); #1;
    bus.cmd_valid = 0;
    exp_ready = 0; exp_addr = 2'd3; exp_rbar = 0;
    rst = 1;
    @(posedge clk); #1;
    set_exp_reset();
    rst = 0;
    chk("abort_read_bar", {7'b0, read_bar}, 8'h01);
    @(posedge clk); #1;
    exp_cs = 1; exp_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_rsp", {7'b0, bus.rsp_valid}, 8'h00);
    chk("abort_mem_kept", bmem[3], 8'hC3);
    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
